// File: rtl/mem_bus_ctrl.sv
// Data-memory bus controller: turns the MEM stage's one-cycle load/store request
// into a registered req/ack bus transaction and stalls the pipeline until it completes.
module mem_bus_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_re,
   input  logic [31:0] mem_read_addr,
   input  logic        mem_we,
   input  logic [31:0] mem_write_addr,
   input  logic [3:0]  mem_write,
   input  logic [31:0] mem_write_instr,
   output logic [31:0] mem_data_o,
   output logic        stall_req,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [31:0] LAST_CNT = (TIMEOUT == 32'd0) ? 32'd0 : TIMEOUT - 32'd1;
   localparam bit          TO_EN    = (TIMEOUT != 32'd0);

   state_t      state;
   state_t      next_state;
   logic [31:0] counter;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        req;
   logic        timeout_hit;

   assign req = mem_we | mem_re;

   // Next-state decode and the combinational pipeline-facing outputs
   always_comb begin
      next_state  = state;
      timeout_hit = 1'b0;
      stall_req   = 1'b0;
      mem_data_o  = 32'd0;
      bus_err     = 1'b0;
      case (state)
         IDLE: begin
            // rst gate keeps stall low while reset is held with a request pending
            stall_req = req & ~rst;
            if (req) begin
               next_state = WAIT;
            end else begin
               next_state = IDLE;
            end
         end
         WAIT: begin
            stall_req = 1'b1;
            if (bus_ack) begin
               next_state = DONE;
            end else if (TO_EN && (counter == LAST_CNT)) begin
               timeout_hit = 1'b1;
               next_state  = DONE;
            end else begin
               next_state = WAIT;
            end
         end
         DONE: begin
            mem_data_o = rdata_q;
            bus_err    = err_q;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State register, bus request registers, wait counter and read-data latch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         counter   <= 32'd0;
         rdata_q   <= 32'd0;
         err_q     <= 1'b0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'd0;
         bus_sel   <= 4'd0;
         bus_wdata <= 32'd0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               if (req) begin
                  bus_req <= 1'b1;
                  bus_we  <= mem_we;
                  counter <= 32'd0;
                  err_q   <= 1'b0;
                  // write wins when both requests are raised together
                  if (mem_we) begin
                     bus_addr  <= {mem_write_addr[31:2], 2'b00};
                     bus_sel   <= mem_write;
                     bus_wdata <= mem_write_instr;
                  end else begin
                     bus_addr  <= {mem_read_addr[31:2], 2'b00};
                     bus_sel   <= 4'b1111;
                     bus_wdata <= 32'd0;
                  end
               end
            end
            WAIT: begin
               if (bus_ack) begin
                  rdata_q <= bus_we ? 32'd0 : bus_rdata;
                  bus_req <= 1'b0;
               end else if (timeout_hit) begin
                  rdata_q <= 32'd0;
                  bus_req <= 1'b0;
                  err_q   <= 1'b1;
               end else begin
                  counter <= counter + 32'd1;
               end
            end
            DONE: begin
               err_q <= 1'b0;
            end
            default: begin
               bus_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: stimulus queues expected issues/completions,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_bus_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_re, mem_we;
   logic [31:0] mem_read_addr, mem_write_addr, mem_write_instr;
   logic [3:0]  mem_write;
   logic [31:0] mem_data_o;
   logic        stall_req, bus_err, bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_sel;
   logic        bus_ack;

   mem_bus_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .mem_re(mem_re), .mem_read_addr(mem_read_addr),
      .mem_we(mem_we), .mem_write_addr(mem_write_addr),
      .mem_write(mem_write), .mem_write_instr(mem_write_instr),
      .mem_data_o(mem_data_o), .stall_req(stall_req), .bus_err(bus_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_sel(bus_sel), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
   } iss_t;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          stall;
      int          reqc;
   } cmp_t;

   iss_t iss_q[$];
   cmp_t cmp_q[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Monitor: pops the issue queue on a bus_req rise and the completion queue in DONE
   initial begin
      logic prev_req;
      int   stall_cnt;
      int   req_cnt;
      iss_t ei;
      cmp_t ec;
      prev_req = 1'b0; stall_cnt = 0; req_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_req = 1'b0; stall_cnt = 0; req_cnt = 0;
         end else begin
            if (bus_req && !prev_req) begin
               req_cnt = 0;
               if (iss_q.size() == 0) begin
                  check("unexpected_issue", 32'd1, 32'd0);
               end else begin
                  ei = iss_q.pop_front();
                  check("issue_we", {31'd0, bus_we}, {31'd0, ei.we});
                  check("issue_addr", bus_addr, ei.addr);
                  check("issue_sel", {28'd0, bus_sel}, {28'd0, ei.sel});
                  check("issue_wdata", bus_wdata, ei.wdata);
               end
            end
            if (bus_req) req_cnt++;
            if (prev_req && !bus_req) begin
               if (cmp_q.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  ec = cmp_q.pop_front();
                  check("done_data", mem_data_o, ec.data);
                  check("done_err", {31'd0, bus_err}, {31'd0, ec.err});
                  check("done_stall_low", {31'd0, stall_req}, 32'd0);
                  check("stall_cycles", stall_cnt, ec.stall);
                  check("req_cycles", req_cnt, ec.reqc);
               end
               stall_cnt = 0;
            end else begin
               check("quiet_outputs", {mem_data_o[31:1], mem_data_o[0] | bus_err}, 32'd0);
               if (stall_req) stall_cnt++;
               else stall_cnt = 0;
            end
            prev_req = bus_req;
         end
      end
   end

   // Drives one access from IDLE (caller is at posedge+1) back to IDLE
   task automatic access(input logic re, input logic we,
                         input logic [31:0] raddr, input logic [31:0] waddr,
                         input logic [3:0] wsel, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int wait_n, input bit no_ack,
                         input logic e_we, input logic [31:0] e_addr, input logic [3:0] e_sel,
                         input logic [31:0] e_wdata, input logic [31:0] e_data,
                         input logic e_err, input int e_stall, input int e_reqc);
      iss_t i;
      cmp_t c;
      i.we = e_we; i.addr = e_addr; i.sel = e_sel; i.wdata = e_wdata;
      c.data = e_data; c.err = e_err; c.stall = e_stall; c.reqc = e_reqc;
      iss_q.push_back(i);
      cmp_q.push_back(c);
      mem_re = re; mem_we = we; mem_read_addr = raddr; mem_write_addr = waddr;
      mem_write = wsel; mem_write_instr = wdata;
      @(posedge clk); #1;
      if (!no_ack) begin
         repeat (wait_n) begin @(posedge clk); #1; end
         bus_ack = 1'b1; bus_rdata = rdata;
         @(posedge clk); #1;
         bus_ack = 1'b0; bus_rdata = 32'd0;
      end else begin
         repeat (TO) begin @(posedge clk); #1; end
      end
      @(posedge clk); #1;
      mem_re = 1'b0; mem_we = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; mem_re = 1'b0; mem_we = 1'b0; mem_read_addr = 32'd0;
      mem_write_addr = 32'd0; mem_write = 4'd0; mem_write_instr = 32'd0;
      bus_rdata = 32'd0; bus_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_bus_req", {31'd0, bus_req}, 32'd0);
      check("rst_stall", {31'd0, stall_req}, 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_mem_data", mem_data_o, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // lw 0x1004, ack on second wait cycle
      access(1'b1, 1'b0, 32'h1004, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 1, 1'b0,
             1'b0, 32'h1004, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0, 3, 2);
      // sb 0x2003, zero-wait; written rdata must not reach mem_data_o
      access(1'b0, 1'b1, 32'h0, 32'h2003, 4'b0001, 32'h5A5A5A5A, 32'hFFFFFFFF, 0, 1'b0,
             1'b1, 32'h2000, 4'b0001, 32'h5A5A5A5A, 32'h0, 1'b0, 2, 1);
      // lw with no ack: timeout after TO wait cycles
      access(1'b1, 1'b0, 32'h0300, 32'h0, 4'h0, 32'h0, 32'h0, 0, 1'b1,
             1'b0, 32'h0300, 4'b1111, 32'h0, 32'h0, 1'b1, 5, 4);
      // ack on the final allowed wait cycle beats the timeout
      access(1'b1, 1'b0, 32'h0402, 32'h0, 4'h0, 32'h0, 32'hCAFEF00D, 3, 1'b0,
             1'b0, 32'h0400, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0, 5, 4);
      // back-to-back lw 0x10 then sw 0x14
      access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 32'h01020304, 0, 1'b0,
             1'b0, 32'h10, 4'b1111, 32'h0, 32'h01020304, 1'b0, 2, 1);
      access(1'b0, 1'b1, 32'h0, 32'h14, 4'b1111, 32'hA5A5A5A5, 32'h0, 0, 1'b0,
             1'b1, 32'h14, 4'b1111, 32'hA5A5A5A5, 32'h0, 1'b0, 2, 1);
      // both requests at once: write wins
      access(1'b1, 1'b1, 32'h3000, 32'h4008, 4'b1100, 32'h11223344, 32'h99999999, 0, 1'b0,
             1'b1, 32'h4008, 4'b1100, 32'h11223344, 32'h0, 1'b0, 2, 1);

      // stray ack in IDLE
      bus_ack = 1'b1; bus_rdata = 32'h77777777;
      repeat (2) begin @(posedge clk); #1; end
      check("stray_ack_req", {31'd0, bus_req}, 32'd0);
      check("stray_ack_stall", {31'd0, stall_req}, 32'd0);
      bus_ack = 1'b0; bus_rdata = 32'd0;
      @(posedge clk); #1;

      // reset in the middle of WAIT abandons the access
      iss_q.push_back('{we: 1'b0, addr: 32'h0500, sel: 4'b1111, wdata: 32'h0});
      mem_re = 1'b1; mem_read_addr = 32'h0500;
      @(posedge clk); #1;
      @(posedge clk); #2;
      check("pre_rst_req", {31'd0, bus_req}, 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_req", {31'd0, bus_req}, 32'd0);
      check("midrst_stall", {31'd0, stall_req}, 32'd0);
      check("midrst_addr", bus_addr, 32'd0);
      check("midrst_sel", {28'd0, bus_sel}, 32'd0);
      check("midrst_data", mem_data_o | {31'd0, bus_err}, 32'd0);
      mem_re = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      access(1'b1, 1'b0, 32'h88, 32'h0, 4'h0, 32'h0, 32'h12345678, 0, 1'b0,
             1'b0, 32'h88, 4'b1111, 32'h0, 32'h12345678, 1'b0, 2, 1);

      repeat (3) @(posedge clk);
      check("issue_q_empty", iss_q.size(), 32'd0);
      check("cmp_q_empty", cmp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
